// File: rtl/mc_pkg.sv
// ============================================================================
// Module   : mc_pkg
// Purpose  : Shared types and encodings for the multicycle MIPS controller.
//            Optional bne support is selected with the MC_BNE_EN macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_RTYPEEX = 4'd6,
        ST_RTYPEWB = 4'd7,
        ST_BEQEX   = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JEX     = 4'd11,
        ST_ORIEX   = 4'd12,
        ST_ORIWB   = 4'd13,
        ST_BNEEX   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    // Everything the FSM registers per state; zero is the all-idle value.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
`ifdef MC_BNE_EN
        logic       bne;
`endif
        logic       memwrite;
        logic       irwrite;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zext;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       instr_done;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mc_controller_aludec.sv
// ============================================================================
// Module   : mc_controller_aludec
// Purpose  : ALU decoder: maps aluop and the R-type funct field to alucontrol.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_controller_aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALUCTL_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUCTL_ADD;
            ALUOP_SUB: alucontrol = ALUCTL_SUB;
            ALUOP_OR:  alucontrol = ALUCTL_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALUCTL_ADD;
                    FUNCT_SUB: alucontrol = ALUCTL_SUB;
                    FUNCT_AND: alucontrol = ALUCTL_AND;
                    FUNCT_OR:  alucontrol = ALUCTL_OR;
                    FUNCT_SLT: alucontrol = ALUCTL_SLT;
                    default:   alucontrol = ALUCTL_AND;
                endcase
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// Module   : mc_controller
// Purpose  : Multicycle MIPS main control FSM with registered Moore outputs.
//            Define MC_BNE_EN to add the bne instruction (state BNEEX).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_controller
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               memwrite,
    output logic               irwrite,
    output logic               iord,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               zext,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    generate
        if (STATE_W < 4) begin : g_state_w_check
            $error("mc_controller: STATE_W must be at least 4");
        end
    endgenerate

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   w_op_legal;
    logic   w_illegal_done;

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.irwrite = 1'b1;
                c.alusrcb = 2'b01;
                c.pcwrite = 1'b1;
            end
            ST_DECODE: c.alusrcb = 2'b11;
            ST_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ST_MEMRD: c.iord = 1'b1;
            ST_MEMWB: begin
                c.memtoreg   = 1'b1;
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                c.iord       = 1'b1;
                c.memwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            ST_RTYPEWB: begin
                c.regdst     = 1'b1;
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_BEQEX: begin
                c.alusrca    = 1'b1;
                c.aluop      = ALUOP_SUB;
                c.pcsrc      = 2'b01;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ST_ADDIWB, ST_ORIWB: begin
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_JEX: begin
                c.pcsrc      = 2'b10;
                c.pcwrite    = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_ORIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.zext    = 1'b1;
                c.aluop   = ALUOP_OR;
            end
`ifdef MC_BNE_EN
            ST_BNEEX: begin
                c.alusrca    = 1'b1;
                c.aluop      = ALUOP_SUB;
                c.pcsrc      = 2'b01;
                c.bne        = 1'b1;
                c.instr_done = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next     = ST_FETCH;
        w_op_legal = 1'b1;
        case (r_state)
            ST_FETCH: w_next = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_RTYPE:     w_next = ST_RTYPEEX;
                    OP_BEQ:       w_next = ST_BEQEX;
                    OP_ADDI:      w_next = ST_ADDIEX;
                    OP_J:         w_next = ST_JEX;
                    OP_ORI:       w_next = ST_ORIEX;
`ifdef MC_BNE_EN
                    OP_BNE:       w_next = ST_BNEEX;
`endif
                    default: begin
                        w_next     = ST_FETCH;
                        w_op_legal = 1'b0;
                    end
                endcase
            end
            ST_MEMADR: begin
                if (op == OP_LW)
                    w_next = ST_MEMRD;
                else if (op == OP_SW)
                    w_next = ST_MEMWR;
                else
                    w_next = ST_FETCH;
            end
            ST_MEMRD:   w_next = ST_MEMWB;
            ST_RTYPEEX: w_next = ST_RTYPEWB;
            ST_ADDIEX:  w_next = ST_ADDIWB;
            ST_ORIEX:   w_next = ST_ORIWB;
            default:    w_next = ST_FETCH;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet still Moore.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_ctrl  <= ctrl_for(ST_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next);
        end
    end

    // An illegal opcode ends in DECODE, which only the opcode itself can tell.
    assign w_illegal_done = (r_state == ST_DECODE) && !w_op_legal;

`ifdef MC_BNE_EN
    assign pcen = r_ctrl.pcwrite | (r_ctrl.branch & zero) | (r_ctrl.bne & ~zero);
`else
    assign pcen = r_ctrl.pcwrite | (r_ctrl.branch & zero);
`endif

    assign memwrite   = r_ctrl.memwrite;
    assign irwrite    = r_ctrl.irwrite;
    assign iord       = r_ctrl.iord;
    assign regwrite   = r_ctrl.regwrite;
    assign regdst     = r_ctrl.regdst;
    assign memtoreg   = r_ctrl.memtoreg;
    assign alusrca    = r_ctrl.alusrca;
    assign alusrcb    = r_ctrl.alusrcb;
    assign zext       = r_ctrl.zext;
    assign pcsrc      = r_ctrl.pcsrc;
    assign instr_done = r_ctrl.instr_done | w_illegal_done;
    assign state      = STATE_W'(r_state);

    mc_controller_aludec u_aludec (
        .aluop      (r_ctrl.aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main control unit for the multicycle MIPS datapath.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.
- Drives every datapath enable and mux select, and derives `alucontrol` through an internal ALU decoder.
- Sits between the instruction register (`op`/`funct`) and the shared ALU, register file and unified memory.

Parameters:
- STATE_W, 4: width of the state register and of the debug `state` output; must be ≥4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; forces FETCH on the next rising edge
- op  in  6  instruction opcode, IR[31:26]
- funct  in  6  R-type function field, IR[5:0]
- zero  in  1  ALU zero flag, same cycle as the branch compare
- pcen  out  1  PC register enable; `pcen = pcwrite | (branch & zero)`
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- regwrite  out  1  register file write enable
- regdst  out  1  write register select: 1 = rd, 0 = rt
- memtoreg  out  1  writeback source: 1 = Data register, 0 = ALUOut
- alusrca  out  1  SrcA select: 0 = PC, 1 = A register
- alusrcb  out  2  SrcB select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- zext  out  1  immediate extend: 1 = zero-extend (ORI), 0 = sign-extend
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
- instr_done  out  1  asserted during the final cycle of each instruction
- state  out  STATE_W  current state, for debug

Behaviour:
- Moore outputs: a pure function of state, except `pcen` (uses `zero`) and `alucontrol` (uses `funct` in RTYPEEX).
- Every output not listed for a state is 0; `aluop` defaults to 00.
- Reset: state = FETCH (0) on the edge where `reset` = 1. Reset mid-instruction abandons the instruction; writes already issued are not undone. While `reset` is high, outputs follow the current state until that edge.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, ORIEX 12, ORIWB 13.
- FETCH: `irwrite` = 1, `alusrcb` = 01, `pcwrite` = 1, aluop 00. Next: DECODE.
- DECODE: `alusrcb` = 11, aluop 00 (branch target precompute). Next by `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - 001101 (ori) → ORIEX
  - any other opcode → FETCH with `instr_done` = 1; treated as a NOP with no write strobes.
- MEMADR: `alusrca` = 1, `alusrcb` = 10. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: `iord` = 1. Next: MEMWB.
- MEMWB: `memtoreg` = 1, `regwrite` = 1, `instr_done` = 1. Next: FETCH.
- MEMWR: `iord` = 1, `memwrite` = 1, `instr_done` = 1. Next: FETCH.
- RTYPEEX: `alusrca` = 1, `alusrcb` = 00, aluop 10. Next: RTYPEWB.
- RTYPEWB: `regdst` = 1, `regwrite` = 1, `instr_done` = 1. Next: FETCH.
- BEQEX: `alusrca` = 1, aluop 01, `pcsrc` = 01, `branch` = 1, `instr_done` = 1. Next: FETCH.
- ADDIEX: `alusrca` = 1, `alusrcb` = 10, aluop 00. Next: ADDIWB.
- ADDIWB / ORIWB: `regwrite` = 1, `instr_done` = 1. Next: FETCH.
- JEX: `pcsrc` = 10, `pcwrite` = 1, `instr_done` = 1. Next: FETCH.
- ORIEX: `alusrca` = 1, `alusrcb` = 10, `zext` = 1, aluop 11. Next: ORIWB.
- Internal `pcwrite` and `branch` exist only to form `pcen`; `pcen` is combinational.
- Unused state codes (14, 15) → FETCH next cycle, all outputs 0.
- Cycle counts: lw 5, sw 4, R-type / addi / ori 4, beq / j 3, illegal opcode 2.

Optional Feature:
- Macro: MC_BNE_EN.
- When defined:
  - opcode 000101 (bne) in DECODE → BNEEX (code 14).
  - BNEEX has the same outputs as BEQEX, except `branch` = 0 and `bne` = 1.
  - `pcen = pcwrite | (branch & zero) | (bne & ~zero)`.
- When undefined: 000101 is an illegal opcode (DECODE → FETCH), and code 14 is unused.

Decomposition:
- Shared package `mc_pkg`:
  - state enum/constants
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_ORI)
  - ALUOP_ADD / SUB / FUNCT / OR
  - alucontrol codes
- Sub-module: the existing ALU decoder, instantiated unchanged, mapping `aluop` + `funct` → `alucontrol`.
- The FSM (main decoder) lives in mc_controller.

Test Plan:
- reset = 1 for 2 cycles mid-RTYPEEX → state = 0 after the edge; FETCH outputs `irwrite` = 1, `pcen` = 1, `alusrcb` = 01, `alucontrol` = 010.
- lw (op 100011) → states 0,1,2,3,4; `iord` = 1 in state 3; `regwrite` = `memtoreg` = 1 only in state 4; `instr_done` = 1 only in state 4.
- R-type add, then slt (funct 100000, 101010) → RTYPEEX `alucontrol` = 010, then 111; RTYPEWB `regdst` = 1, `regwrite` = 1.
- beq with `zero` = 1 vs `zero` = 0 → BEQEX `pcen` = 1 vs 0; `pcsrc` = 01; `alucontrol` = 110; next state FETCH.
- ori (001101) → ORIEX `zext` = 1, `alusrcb` = 10, `alucontrol` = 001; ORIWB `regdst` = 0, `regwrite` = 1. j (000010) → JEX `pcsrc` = 10, `pcen` = 1.
- op 000101: with MC_BNE_EN, `zero` = 0 → `pcen` = 1, and `zero` = 1 → `pcen` = 0. Without MC_BNE_EN → DECODE → FETCH, no write strobes.
